led_pwm_fader: RTL and testbench

//  Downstream consumer of the top-level LED pattern generator. Takes the 6-bit
//  LED pattern plus a global gate and drives the board LEDs through per-channel
//  PWM with linear fade-in/fade-out. Replaces the hard on/off LED drive with

---
 rtl/led_pwm_fader.sv | 116 +++++++++++
 tb/tb_led_pwm_fader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_fader.sv
// Per-channel LED PWM driver with linear fade-in/fade-out ramps.
// Each channel walks its brightness one step per tick towards its requested on/off target.
module led_pwm_fader #(
  parameter int N        = 6,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 195312
) (
  input  logic         clk50,
  input  logic         rst_n,
  input  logic [N-1:0] pattern_in,
  input  logic         pattern_valid,
  input  logic         gate_in,
  output logic [N-1:0] led_out,
  output logic         busy
);

  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PWM_BITS-1:0] MAX       = '1;
  localparam logic [PWM_BITS-1:0] ONE       = PWM_BITS'(1);
  localparam logic [STEP_W-1:0]   STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_UP,
    ST_ON,
    ST_DOWN
  } chan_state_t;

  logic [PWM_BITS-1:0]          pwm_cnt;
  logic [STEP_W-1:0]            step_cnt;
  logic                         tick;
  logic [N-1:0]                 target;
  logic [N-1:0][PWM_BITS-1:0]   bright;
  logic [N-1:0][PWM_BITS-1:0]   bright_nxt;
  chan_state_t                  state     [N];
  chan_state_t                  state_nxt [N];
  logic [N-1:0]                 ramping;
  logic [N-1:0]                 led_nxt;

  assign tick = (step_cnt == STEP_LAST);

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bright_nxt[i] = bright[i];
      state_nxt[i]  = state[i];
      ramping[i]    = (state[i] == ST_UP) || (state[i] == ST_DOWN);
      led_nxt[i]    = gate_in & ((bright[i] == MAX) | (bright[i] > pwm_cnt));

      // Targets are registered, so a load on a tick edge only affects the next tick.
      if (tick) begin
        unique case (state[i])
          ST_OFF: begin
            if (target[i]) begin
              bright_nxt[i] = bright[i] + ONE;
              state_nxt[i]  = (bright_nxt[i] == MAX) ? ST_ON : ST_UP;
            end
          end
          ST_UP, ST_DOWN: begin
            if (target[i]) begin
              bright_nxt[i] = bright[i] + ONE;
              state_nxt[i]  = (bright_nxt[i] == MAX) ? ST_ON : ST_UP;
            end else begin
              bright_nxt[i] = bright[i] - ONE;
              state_nxt[i]  = (bright_nxt[i] == '0) ? ST_OFF : ST_DOWN;
            end
          end
          ST_ON: begin
            if (!target[i]) begin
              bright_nxt[i] = bright[i] - ONE;
              state_nxt[i]  = (bright_nxt[i] == '0) ? ST_OFF : ST_DOWN;
            end
          end
          default: begin
            bright_nxt[i] = '0;
            state_nxt[i]  = ST_OFF;
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
      target   <= '0;
      // NOTE: the per-channel arrays are a handful of flops, not RAM, so they
      // are cleared here; a mid-ramp reset must leave no brightness behind.
      bright   <= '0;
      for (int i = 0; i < N; i++) begin
        state[i] <= ST_OFF;
      end
      led_out  <= '0;
      busy     <= 1'b0;
    end else begin
      pwm_cnt  <= pwm_cnt + ONE;
      step_cnt <= tick ? '0 : step_cnt + STEP_ONE;
      if (pattern_valid) begin
        target <= pattern_in;
      end
      bright   <= bright_nxt;
      for (int i = 0; i < N; i++) begin
        state[i] <= state_nxt[i];
      end
      led_out  <= led_nxt;
      busy     <= |ramping;
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Randomized and directed bench for led_pwm_fader against a brightness-level model.
// A second, slow-stepping instance measures steady-state PWM duty.
module tb_led_pwm_fader;

  localparam int N       = 6;
  localparam int PB      = 4;
  localparam int MAXV    = 15;
  localparam int SD      = 4;
  localparam int SD_SLOW = 64;

  logic         clk50 = 1'b0;
  logic         rst_n;
  logic [N-1:0] pattern_in;
  logic         pattern_valid;
  logic         gate_in;
  logic [N-1:0] led_out;
  logic         busy;

  logic         rst_s_n;
  logic [N-1:0] pattern_s;
  logic         valid_s;
  logic         gate_s;
  logic [N-1:0] led_s;
  logic         busy_s;

  always #5 clk50 = ~clk50;

  led_pwm_fader #(.N(N), .PWM_BITS(PB), .STEP_DIV(SD)) dut (
    .clk50         (clk50),
    .rst_n         (rst_n),
    .pattern_in    (pattern_in),
    .pattern_valid (pattern_valid),
    .gate_in       (gate_in),
    .led_out       (led_out),
    .busy          (busy)
  );

  led_pwm_fader #(.N(N), .PWM_BITS(PB), .STEP_DIV(SD_SLOW)) dut_slow (
    .clk50         (clk50),
    .rst_n         (rst_s_n),
    .pattern_in    (pattern_s),
    .pattern_valid (valid_s),
    .gate_in       (gate_s),
    .led_out       (led_s),
    .busy          (busy_s)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Reference model: brightness as plain integers, updated per the fade rules.
  int           m_bright [N];
  int           m_target [N];
  int           m_pwm;
  int           m_step;
  logic [N-1:0] m_led;
  logic         m_busy;

  always @(posedge clk50) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_bright[i] = 0;
        m_target[i] = 0;
      end
      m_pwm  = 0;
      m_step = 0;
      m_led  = '0;
      m_busy = 1'b0;
    end else begin
      m_busy = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_led[i] = gate_in && (m_bright[i] == MAXV || m_bright[i] > m_pwm);
        if (m_bright[i] > 0 && m_bright[i] < MAXV) m_busy = 1'b1;
      end
      if (m_step == SD - 1) begin
        for (int i = 0; i < N; i++) begin
          if (m_target[i] != 0) m_bright[i] = (m_bright[i] < MAXV) ? m_bright[i] + 1 : MAXV;
          else                  m_bright[i] = (m_bright[i] > 0) ? m_bright[i] - 1 : 0;
        end
      end
      if (pattern_valid) begin
        for (int i = 0; i < N; i++) m_target[i] = pattern_in[i] ? 1 : 0;
      end
      m_pwm  = (m_pwm + 1) % (MAXV + 1);
      m_step = (m_step + 1) % SD;
    end
  end

  bit mon_en = 1'b0;

  always @(negedge clk50) begin
    if (mon_en) begin
      check("led_out", 32'(led_out), 32'(m_led));
      check("busy", 32'(busy), 32'(m_busy));
      for (int i = 0; i < N; i++) begin
        check($sformatf("bright%0d", i), 32'(dut.bright[i]), m_bright[i]);
      end
    end
  end

  // Advance to the first negedge that follows a tick edge.
  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk50);
      n++;
    end while (m_step != 0 && n < 2 * SD);
    if (m_step != 0) check("tick_timeout", 0, 1);
  endtask

  task automatic load(input logic [N-1:0] pat);
    pattern_in    = pat;
    pattern_valid = 1'b1;
    @(negedge clk50);
    pattern_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] acc;
    logic         all_on;
    int           hi;
    int           lo;
    int           n;

    rst_n = 1'b0; pattern_in = '0; pattern_valid = 1'b0; gate_in = 1'b0;
    rst_s_n = 1'b0; pattern_s = '0; valid_s = 1'b0; gate_s = 1'b1;

    // Reset held with random inputs.
    @(negedge clk50);
    mon_en = 1'b1;
    repeat (3) begin
      pattern_in    = N'($urandom);
      pattern_valid = 1'($urandom);
      gate_in       = 1'($urandom);
      @(negedge clk50);
    end
    check("rst_led", 32'(led_out), 0);
    check("rst_busy", 32'(busy), 0);

    rst_n = 1'b1;
    pattern_valid = 1'b0;
    acc = '0;
    repeat (200) begin
      gate_in = 1'($urandom);
      @(negedge clk50);
      acc |= led_out;
    end
    check("idle_led", 32'(acc), 0);

    // Fade-in on channel 0.
    gate_in = 1'b1;
    wait_tick();
    load(6'b000001);
    for (int k = 1; k <= MAXV; k++) begin
      wait_tick();
      check("fade_bright", 32'(dut.bright[0]), k);
      if (k >= 2) check("fade_busy", 32'(busy), 1);
    end
    @(negedge clk50);
    check("fade_busy_end", 32'(busy), 0);
    all_on = 1'b1;
    acc = '0;
    repeat (16) begin
      all_on &= led_out[0];
      acc    |= led_out & 6'b111110;
      @(negedge clk50);
    end
    check("full_led0", 32'(all_on), 1);
    check("full_others", 32'(acc), 0);

    // Reversal on channel 2 from brightness 5.
    wait_tick();
    load(6'b000101);
    for (int k = 1; k <= 5; k++) wait_tick();
    check("rev_peak", 32'(dut.bright[2]), 5);
    load(6'b000001);
    for (int k = 4; k >= 0; k--) begin
      wait_tick();
      check("rev_bright", 32'(dut.bright[2]), k);
    end
    check("rev_busy_hold", 32'(busy), 1);
    @(negedge clk50);
    check("rev_busy_fall", 32'(busy), 0);
    check("rev_ch0_full", 32'(dut.bright[0]), MAXV);

    // Load on a tick edge uses the old target.
    n = 0;
    while (m_step != SD - 1 && n < 2 * SD) begin
      @(negedge clk50);
      n++;
    end
    check("coll_align", m_step, SD - 1);
    load(6'b001001);
    check("coll_old", 32'(dut.bright[3]), 0);
    wait_tick();
    check("coll_new", 32'(dut.bright[3]), 1);

    // Gate off mid-ramp.
    wait_tick();
    @(negedge clk50);
    gate_in = 1'b0;
    @(negedge clk50);
    check("gate_led", 32'(led_out), 0);
    wait_tick();
    check("gate_bright", 32'(dut.bright[3]), 3);
    check("gate_busy", 32'(busy), 1);
    gate_in = 1'b1;

    // All channels ramping, then a one-cycle reset.
    wait_tick();
    load(6'b001000);
    wait_tick();
    wait_tick();
    load(6'b111111);
    wait_tick();
    check("mr_ch0", 32'(dut.bright[0]), 14);
    check("mr_ch1", 32'(dut.bright[1]), 1);
    @(negedge clk50);
    rst_n = 1'b0;
    @(negedge clk50);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) check($sformatf("mr_bright%0d", i), 32'(dut.bright[i]), 0);
    check("mr_led", 32'(led_out), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_step", 32'(dut.step_cnt), 0);
    acc = '0;
    repeat (20) begin
      @(negedge clk50);
      acc |= led_out;
    end
    check("mr_after_led", 32'(acc), 0);

    // Random traffic, checked by the model every cycle.
    repeat (400) begin
      pattern_in    = N'($urandom);
      pattern_valid = ($urandom_range(0, 7) == 0);
      gate_in       = ($urandom_range(0, 9) != 0);
      @(negedge clk50);
    end
    pattern_valid = 1'b0;
    mon_en = 1'b0;

    // Steady-state duty on the slow instance.
    rst_s_n = 1'b0;
    @(negedge clk50);
    rst_s_n   = 1'b1;
    pattern_s = 6'b000001;
    valid_s   = 1'b1;
    @(negedge clk50);
    valid_s = 1'b0;
    repeat (519) @(negedge clk50);
    check("duty_bright", 32'(dut_slow.bright[0]), 8);
    hi = 0;
    lo = 0;
    for (int j = 0; j < 16; j++) begin
      hi += int'(led_s[0]);
      lo += int'(led_s[1]);
      @(negedge clk50);
    end
    check("duty8_high", hi, 8);
    check("duty_off_ch", lo, 0);
    repeat (464) @(negedge clk50);
    hi = 0;
    for (int j = 0; j < 16; j++) begin
      hi += int'(led_s[0]);
      @(negedge clk50);
    end
    check("duty_full_high", hi, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
